// File: rtl/uart_rx_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_fifo_param                                         |
// | Description : UART receive FIFO with watermark interrupt, sticky         |
// |               overflow flag and optional idle timeout interrupt          |
// |               (enabled by macro UART_RX_FIFO_TIMEOUT_EN).                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_i,
  input  logic [AW:0]       thresh_i,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  input  logic [15:0]       timeout_i,
  output logic              intr_timeout_o,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              intr_thresh_o,
  output logic              overflow_o,
  output logic              rd_valid_o
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;
  logic              r_intr_thresh;
  logic              r_rd_valid;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en && !w_empty;
  // A read in the same cycle frees the slot, so a write at full is still taken.
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  // Storage is not reset; a flush leaves the contents untouched.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc && !clr_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_data        <= '0;
      r_overflow    <= 1'b0;
      r_intr_thresh <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_intr_thresh <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_rd_valid    <= w_rd_acc;
      r_intr_thresh <= (thresh_i != '0) && (r_count >= thresh_i);
      if (wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] r_idle;
  logic        r_intr_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle         <= '0;
      r_intr_timeout <= 1'b0;
    end else begin
      r_intr_timeout <= (timeout_i != '0) && (r_idle >= timeout_i);
      if (w_wr_acc || w_rd_acc || clr_i || w_empty) begin
        r_idle <= '0;
      end else if (r_idle != 16'hFFFF) begin
        r_idle <= r_idle + 16'd1;
      end
    end
  end

  assign intr_timeout_o = r_intr_timeout;
`endif

  assign data_o        = r_data;
  assign count_o       = r_count;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign intr_thresh_o = r_intr_thresh;
  assign overflow_o    = r_overflow;
  assign rd_valid_o    = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo_param                                      |
// | Description : Directed self-checking bench for uart_rx_fifo_param        |
// |               (DEPTH=16, DATA_W=8; timeout checks under                  |
// |               UART_RX_FIFO_TIMEOUT_EN).                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo_param;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_i = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_i = 1'b0;
  logic [4:0] thresh_i = '0;
  logic [7:0] data_o;
  logic [4:0] count_o;
  logic       full_o;
  logic       empty_o;
  logic       intr_thresh_o;
  logic       overflow_o;
  logic       rd_valid_o;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] timeout_i = '0;
  logic        intr_timeout_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .clr_i         (clr_i),
    .thresh_i      (thresh_i),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeout_i     (timeout_i),
    .intr_timeout_o(intr_timeout_o),
`endif
    .data_o        (data_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .intr_thresh_o (intr_thresh_o),
    .overflow_o    (overflow_o),
    .rd_valid_o    (rd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_rdv", 32'(rd_valid_o), 32'd0);
    chk("rst_thr", 32'(intr_thresh_o), 32'd0);
    tick();
    rst_ni = 1'b1;

    // Fill to full, then one dropped write
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = 8'(i);
      tick();
    end
    chk("fill_count", 32'(count_o), 32'd16);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ovf", 32'(overflow_o), 32'd0);
    data_i = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd16);
    chk("ovf_thr0", 32'(intr_thresh_o), 32'd0);

    // Drain in order
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_data", 32'(data_o), 32'(i));
      chk("drain_rdv", 32'(rd_valid_o), 32'd1);
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    tick();
    rd_en = 1'b0;
    chk("rd_empty_rdv", 32'(rd_valid_o), 32'd0);
    chk("rd_empty_data", 32'(data_o), 32'h0F);
    chk("rd_empty_count", 32'(count_o), 32'd0);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Pointer wrap: three rounds of 10 in, 10 out
    for (int r = 0; r < 3; r++) begin
      wr_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
        data_i = 8'(8'h30 + r*16 + i);
        tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("wrap_data", 32'(data_o), 32'(8'h30 + r*16 + i));
      end
      rd_en = 1'b0;
    end
    chk("wrap_empty", 32'(empty_o), 32'd1);

    // Flush clears overflow, holds data_o
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_ovf", 32'(overflow_o), 32'd0);
    chk("clr_data_held", 32'(data_o), 32'h59);

    // Simultaneous write+read at full
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = 8'(8'h40 + i);
      tick();
    end
    rd_en = 1'b1;
    data_i = 8'h99;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("fullrw_count", 32'(count_o), 32'd16);
    chk("fullrw_data", 32'(data_o), 32'h40);
    chk("fullrw_rdv", 32'(rd_valid_o), 32'd1);
    chk("fullrw_ovf", 32'(overflow_o), 32'd0);
    rd_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("fullrw_drain", 32'(data_o), 32'(8'h40 + i));
    end
    tick();
    rd_en = 1'b0;
    chk("fullrw_last", 32'(data_o), 32'h99);
    chk("fullrw_empty", 32'(empty_o), 32'd1);

    // Simultaneous write+read on empty: write only
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_i = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("emptyrw_count", 32'(count_o), 32'd1);
    chk("emptyrw_rdv", 32'(rd_valid_o), 32'd0);
    chk("emptyrw_data", 32'(data_o), 32'h99);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("emptyrw_read", 32'(data_o), 32'h77);

    // Watermark at 4
    thresh_i = 5'd4;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'(8'h50 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("thr_lat0", 32'(intr_thresh_o), 32'd0);
    tick();
    chk("thr_set", 32'(intr_thresh_o), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("thr_hold", 32'(intr_thresh_o), 32'd1);
    tick();
    chk("thr_drop", 32'(intr_thresh_o), 32'd0);
    thresh_i = 5'd0;
    wr_en = 1'b1;
    data_i = 8'h60;
    tick();
    data_i = 8'h61;
    tick();
    wr_en = 1'b0;
    tick();
    chk("thr_disabled", 32'(intr_thresh_o), 32'd0);
    thresh_i = 5'd17;
    tick();
    chk("thr_above_depth", 32'(intr_thresh_o), 32'd0);
    thresh_i = 5'd2;
    tick();
    chk("thr_pre_clr", 32'(intr_thresh_o), 32'd1);

    // Flush with 5 stored; clr wins over a concurrent write
    chk("pre_clr_count", 32'(count_o), 32'd5);
    clr_i = 1'b1;
    wr_en = 1'b1;
    data_i = 8'hEE;
    tick();
    clr_i = 1'b0;
    wr_en = 1'b0;
    chk("clr_count", 32'(count_o), 32'd0);
    chk("clr_empty", 32'(empty_o), 32'd1);
    chk("clr_thr", 32'(intr_thresh_o), 32'd0);
    chk("clr_data", 32'(data_o), 32'h50);
    thresh_i = 5'd0;

    // Reset in the middle of a write burst
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'(8'hC0 + i);
      tick();
    end
    rd_en = 1'b1;
    tick();
    rst_ni = 1'b0;
    #2;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_rdv", 32'(rd_valid_o), 32'd0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_ni = 1'b1;
    tick();
    chk("post_rst_count", 32'(count_o), 32'd0);
    chk("post_rst_empty", 32'(empty_o), 32'd1);
    wr_en = 1'b1;
    data_i = 8'h12;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_rst_read", 32'(data_o), 32'h12);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // Idle timeout of 8 cycles
    timeout_i = 16'd8;
    wr_en = 1'b1;
    data_i = 8'h21;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("tmo_early", 32'(intr_timeout_o), 32'd0);
    tick();
    chk("tmo_set", 32'(intr_timeout_o), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("tmo_read", 32'(data_o), 32'h21);
    tick();
    chk("tmo_clear", 32'(intr_timeout_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
